// File: rtl/ball_pair_collision_scanner.sv
// Scans all unordered ball pairs through a 3-stage squared-distance pipeline and streams colliding pairs.
// Define COLLIDE_MASK_EN to add the per-ball `active` mask input.
module ball_pair_collision_scanner #(
    parameter int N         = 32,
    parameter int NUM_BALLS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_BALLS*N-1:0] pos_x,
    input  logic [NUM_BALLS*N-1:0] pos_y,
    input  logic [N-1:0]           radius,
`ifdef COLLIDE_MASK_EN
    input  logic [NUM_BALLS-1:0]   active,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic [IDX_W-1:0]       pair_i,
    output logic [IDX_W-1:0]       pair_j,
    output logic [2*IDX_W-1:0]     collide_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    state_t state;

    logic signed [N-1:0] x_s [NUM_BALLS];
    logic signed [N-1:0] y_s [NUM_BALLS];
    logic signed [N-1:0] r_s;
`ifdef COLLIDE_MASK_EN
    logic [NUM_BALLS-1:0] act_s;
`endif

    logic [IDX_W-1:0] ci, cj;

    logic                s1_v, s1_act;
    logic [IDX_W-1:0]    s1_i, s1_j;
    logic signed [N:0]   s1_dx, s1_dy;

    logic                  s2_v, s2_act;
    logic [IDX_W-1:0]      s2_i, s2_j;
    logic signed [2*N+2:0] s2_d2;
    logic signed [2*N+1:0] s2_thr;

    logic                  stall, last_pair, issue_act, hit, drained;
    logic signed [N:0]     issue_dx, issue_dy, two_r;
    logic signed [2*N+1:0] ext_dx, ext_dy, ext_r, sq_x, sq_y, thr;
    logic signed [2*N+2:0] sum;

    always_comb begin
        stall     = pair_valid && !pair_ready;
        last_pair = (ci == IDX_W'(NUM_BALLS-2)) && (cj == IDX_W'(NUM_BALLS-1));
        issue_dx  = {x_s[ci][N-1], x_s[ci]} - {x_s[cj][N-1], x_s[cj]};
        issue_dy  = {y_s[ci][N-1], y_s[ci]} - {y_s[cj][N-1], y_s[cj]};
`ifdef COLLIDE_MASK_EN
        issue_act = act_s[ci] & act_s[cj];
`else
        issue_act = 1'b1;
`endif
        // Widths chosen so neither the squares nor their sum can wrap.
        ext_dx = {{(N+1){s1_dx[N]}}, s1_dx};
        ext_dy = {{(N+1){s1_dy[N]}}, s1_dy};
        sq_x   = ext_dx * ext_dx;
        sq_y   = ext_dy * ext_dy;
        sum    = {sq_x[2*N+1], sq_x} + {sq_y[2*N+1], sq_y};
        two_r  = {r_s, 1'b0};
        ext_r  = {{(N+1){two_r[N]}}, two_r};
        thr    = ext_r * ext_r;
        hit    = s2_act && (s2_d2 < $signed({s2_thr[2*N+1], s2_thr}));
        // An output being consumed this edge counts as empty so done timing is data independent.
        drained = !s1_v && !s2_v && (!pair_valid || pair_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pair_valid    <= 1'b0;
            pair_i        <= '0;
            pair_j        <= '0;
            collide_count <= '0;
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            ci            <= '0;
            cj            <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        for (int unsigned k = 0; k < NUM_BALLS; k++) begin
                            x_s[k] <= pos_x[k*N +: N];
                            y_s[k] <= pos_y[k*N +: N];
                        end
                        r_s <= radius;
`ifdef COLLIDE_MASK_EN
                        act_s <= active;
`endif
                        collide_count <= '0;
                        ci            <= '0;
                        cj            <= IDX_W'(1);
                        busy          <= 1'b1;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        if (last_pair) begin
                            state <= DRAIN;
                        end else if (cj == IDX_W'(NUM_BALLS-1)) begin
                            ci <= ci + IDX_W'(1);
                            cj <= ci + IDX_W'(2);
                        end else begin
                            cj <= cj + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (!stall) begin
                s1_v   <= (state == SCAN);
                s1_i   <= ci;
                s1_j   <= cj;
                s1_dx  <= issue_dx;
                s1_dy  <= issue_dy;
                s1_act <= issue_act;

                s2_v   <= s1_v;
                s2_i   <= s1_i;
                s2_j   <= s1_j;
                s2_d2  <= sum;
                s2_thr <= thr;
                s2_act <= s1_act;

                pair_valid <= s2_v && hit;
                if (s2_v && hit) begin
                    pair_i        <= s2_i;
                    pair_j        <= s2_j;
                    collide_count <= collide_count + (2*IDX_W)'(1);
                end
            end
        end
    end

endmodule

// File: doc/ball_pair_collision_scanner.md
Name: ball_pair_collision_scanner

Overview:
- Sequential, parametrised successor of the two-ball collision check.
- Snapshots the positions of NUM_BALLS balls and a shared radius on `start`.
- Walks every unordered pair (i<j) through a 3-stage squared-distance pipeline and streams colliding pairs out on a valid/ready interface.
- Sits between the physics state registers and the collision-response unit; runs once per simulation tick.

Parameters:
- N, 32, signed coordinate/radius width.
- NUM_BALLS, 8, ball count; must be ≥2.
- IDX_W, 3, ball index width; must satisfy 2^IDX_W ≥ NUM_BALLS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- pos_x  in  NUM_BALLS*N  packed signed x coordinates; ball k occupies [k*N +: N].
- pos_y  in  NUM_BALLS*N  packed signed y coordinates, same packing as pos_x.
- radius  in  N  signed radius shared by all balls.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the scan has fully drained.
- pair_valid  out  1  a colliding pair is presented.
- pair_ready  in  1  consumer accepts the pair.
- pair_i  out  IDX_W  lower index of the colliding pair.
- pair_j  out  IDX_W  higher index of the colliding pair.
- collide_count  out  2*IDX_W  number of collisions found in the last or current scan.

Behaviour:
- Reset values: busy=0, done=0, pair_valid=0, pair_i=0, pair_j=0, collide_count=0. FSM goes to IDLE; all pipeline valid bits clear.
- FSM states and transitions:
  - IDLE: when start=1, snapshot pos_x, pos_y and radius; clear collide_count; go to SCAN.
  - SCAN: issue one pair per un-stalled cycle. After the last pair (NUM_BALLS-2, NUM_BALLS-1) is issued, go to DRAIN.
  - DRAIN: wait until all pipeline stages and the output register are empty, then go to DONE.
  - DONE: assert done for one cycle; go to IDLE.
- Pair order is lexicographic: (0,1),(0,2)…(0,NB-1),(1,2)…; P = NB*(NB-1)/2 pairs.
- Snapshot: scan results depend only on the values latched at start. Input changes during a scan have no effect.
- Arithmetic, with no wrap-around permitted:
  - dx and dy are sign-extended to N+1 bits before subtraction.
  - Squares are 2N+2 bits; their sum is 2N+3 bits.
  - two_r = 2*radius at N+1 bits; threshold = two_r² at 2N+2 bits.
  - Collision ⇔ dist² < threshold, strictly. Touching balls (dist² == threshold) do not collide.
- Pipeline stages:
  - S1 registers dx and dy.
  - S2 registers the squared sum and the threshold.
  - S3 compares and loads the output register if the pair collides.
  - A non-colliding result never occupies the output.
- Latency: with pair_ready held high, pair k reaches the output 3 cycles after issue. done pulses exactly P+4 cycles after the start-sampling edge.
- Handshake:
  - Transfer occurs when pair_valid && pair_ready.
  - pair_i and pair_j are stable while pair_valid=1 and pair_ready=0.
  - Stall condition is pair_valid && !pair_ready. While stalled, the issue counter and all stages freeze; no pair is lost or duplicated.
- collide_count increments on each collision loaded into the output register. It holds its value after done until the next start.
- start while busy or done: ignored.
- Reset mid-scan: immediate return to IDLE with no done pulse and pair_valid dropped. collide_count clears.

Optional Feature:
- Macro: COLLIDE_MASK_EN.
- When defined:
  - Adds input port `active` [NUM_BALLS-1:0], snapshotted at start.
  - Any pair with an inactive member is treated as non-colliding (e.g. pocketed balls).
  - Cycle timing is unchanged; all P pairs are still issued.
- When undefined: no port is added, and all balls are treated as active.

Test Plan:
- Far apart: NB=4, r=10, balls at (0,0),(100,0),(0,100),(100,100), ready=1 → no pair_valid; collide_count=0; done pulses 10 cycles after start; busy high throughout.
- Touch boundary: NB=2, r=10, balls at (0,0),(20,0) → no collision. Repeat with (0,0),(19,0) → one pair (0,1); collide_count=1.
- Overflow: N=32, r=10, ball0=(0x7FFFFFFF,0), ball1=(0x80000000,0) → no collision, with no false positive from wrapped differences. Also r=0 with coincident balls → no collision.
- Backpressure: NB=4, all balls at (0,0), r=5, pair_ready=0 for 8 cycles then toggled 1/0 → exactly 6 pairs in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); outputs stable while stalled; done only after the last transfer.
- Reset mid-scan: assert reset 3 cycles after start → next cycle busy=0, pair_valid=0, collide_count=0, and no done pulse. A fresh start then produces a full correct scan.
- With COLLIDE_MASK_EN: NB=4, all balls at (0,0), active=4'b1011 → pairs (0,1),(0,3),(1,3) only; collide_count=3; done timing identical to the unmasked case.
